run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side sequencer that sits directly upstream of the processor core: it streams an input message block into data memory, releases the core and raises its `req`, waits for `done`, then streams the result block back out of data memory. It owns the core's reset and a backdoor port to `dat_mem` (muxed in front of the core's own memory port), and reports run cycle count and timeout.

## Interface

**Parameters**
- `LOAD_BASE`, 0, first data-memory address written by the load phase
- `LOAD_LEN`, 30, bytes loaded per run; legal range 1..256
- `DUMP_BASE`, 30, first data-memory address read by the dump phase
- `DUMP_LEN`, 30, bytes dumped per run; legal range 1..256
- `TIMEOUT`, 4096, maximum RUN cycles before abort; at least 2
- `CW`, 16, cycle-counter width; `2**CW` must exceed `TIMEOUT`

**Ports**
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared immediately on assertion
- `start`  in  1  run request; sampled only in IDLE and FINISH
- `in_valid`  in  1  load-stream byte valid
- `in_data`  in  8  load-stream byte
- `in_ready`  out  1  load-stream ready
- `out_valid`  out  1  dump-stream byte valid
- `out_data`  out  8  dump-stream byte
- `out_ready`  in  1  dump-stream ready
- `core_reset`  out  1  active-high reset to the core
- `core_req`  out  1  to the core's `req`
- `core_done`  in  1  from the core's `done`
- `mem_sel`  out  1  1 = sequencer owns the `dat_mem` port
- `mem_wr_en`  out  1  backdoor write enable
- `mem_addr`  out  8  backdoor address
- `mem_wr_dat`  out  8  backdoor write data
- `mem_rd_dat`  in  8  `dat_mem` read data; combinational read of `mem_addr`
- `busy`  out  1  high in LOAD, RUN, DUMP
- `finished`  out  1  high in FINISH
- `timeout`  out  1  last run aborted by timeout
- `cycles`  out  CW  RUN cycles of the last or current run

## Operation

**States:** IDLE, LOAD, RUN, DUMP, FINISH.
- **IDLE:** `core_reset`=1, `mem_sel`=1. On `start`, go to LOAD: clear `idx`, `cycles`, `timeout`.
- **LOAD:** `in_ready`=1 and `mem_wr_en`=`in_valid`. Write uses `mem_addr`=(`LOAD_BASE`+`idx`) mod 256 and `mem_wr_dat`=`in_data`. Each accepted byte increments `idx`. The beat with `idx`=`LOAD_LEN`-1 moves to RUN and clears `idx`.
- **RUN:** `core_reset`=0, `core_req`=1, `mem_sel`=0, `mem_wr_en`=0. `cycles` increments every RUN cycle. `core_done` is ignored in the first RUN cycle.
  - `core_done`=1 (from the 2nd RUN cycle on) goes to DUMP.
  - Otherwise, `cycles`=`TIMEOUT`-1 goes to FINISH with `timeout`=1. If done and timeout coincide, done wins.
- **DUMP:** `core_reset`=1, `mem_sel`=1, `out_valid`=1, `mem_addr`=(`DUMP_BASE`+`idx`) mod 256, `out_data`=`mem_rd_dat`. Each `out_valid`&&`out_ready` increments `idx`. The beat with `idx`=`DUMP_LEN`-1 goes to FINISH. Address and data are held stable while stalled.
- **FINISH:** same as IDLE, plus `finished`=1. On `start`, go to LOAD (flags cleared). `cycles` and `timeout` hold until the next `start`.

**Rules**
- `start` in LOAD/RUN/DUMP is ignored.
- `idx` is 9 bits wide so length 256 counts correctly. Address arithmetic wraps modulo 256.
- Illegal parameters cause an elaboration-time error.

## Timing

- **Reset values:** state=IDLE, `core_reset`=1, `mem_sel`=1. `core_req`, `in_ready`, `out_valid`, `mem_wr_en`, `busy`, `finished`, `timeout` are all 0. `cycles`=0, `mem_addr`=`LOAD_BASE`, `out_data`/`mem_wr_dat` follow their sources.
- `start` at edge N puts the block in LOAD from cycle N+1. `in_ready` is a registered-state decode, not combinational from `in_valid`.
- Memory writes commit on the same edge as the handshake.
- The last load beat at edge M gives the first RUN cycle M+1, with the core out of reset.
- `core_done` seen at edge K gives DUMP at K+1. `core_reset` is reasserted at K+1, so the core's PC clears.
- DUMP throughput is one byte per cycle with `out_ready` held high. Minimum run length is `LOAD_LEN` + 2 + `DUMP_LEN` + 1 cycles.
- Reset asserted mid-operation returns the block to IDLE asynchronously. Partial loads or dumps are discarded, with no further memory writes.

## Structure

- **Package `seq_pkg`:** state enum `seq_state_t` (IDLE, LOAD, RUN, DUMP, FINISH) and the memory address width constant (8).
- **Sub-module `seq_cycle_ctr`:** CW-bit counter with clear, enable and terminal-compare output against `TIMEOUT`-1. It is instantiated once.
- Everything else (state register, `idx`, output decode) stays in `run_sequencer`.

## Test plan

Test parameters: `LOAD_LEN`=4, `DUMP_LEN`=4, `LOAD_BASE`=0, `DUMP_BASE`=8, `TIMEOUT`=20.

- **Normal run:** load 0x11,0x22,0x33,0x44 with `in_valid` held; stub core raises `core_done` 6 RUN cycles after release; memory preloaded 0xA0..0xA3 at 8..11.
  - Required: writes at addresses 0..3 with those bytes.
  - Required: `core_req` high for exactly 6 cycles, `cycles`=6.
  - Required: dump emits 0xA0..0xA3, then `finished`=1, `timeout`=0.
- **Back-pressure:** `in_valid` toggles 1,0,1,0; `out_ready` low for 3 cycles at the second dump byte.
  - Required: only valid beats are written.
  - Required: `out_data`=0xA1 and `mem_addr`=9 stable through the stall; no byte dropped or repeated.
- **Timeout:** core never raises done.
  - Required: FINISH after exactly 20 RUN cycles, `timeout`=1, `cycles`=19, no `out_valid`.
- **Done/timeout collision:** `core_done` asserted on the cycle `cycles`=19.
  - Required: DUMP entered, `timeout`=0.
- **Wrap and ignore:** `LOAD_BASE`=254; `start` pulsed mid-LOAD.
  - Required: writes at 254, 255, 0, 1.
  - Required: the extra `start` has no effect.
- **Async reset mid-RUN:** drop `reset` between edges.
  - Required: immediately IDLE, `core_reset`=1, `core_req`=0, `mem_sel`=1.
  - Required: a subsequent `start` begins a clean LOAD at address 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the run sequencer.
package seq_pkg;

   localparam int ADDR_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      DUMP   = 3'd3,
      FINISH = 3'd4
   } seq_state_t;

endpackage

// File: rtl/seq_cycle_ctr.sv
// RUN-cycle counter: synchronous clear, count enable, terminal flag at TIMEOUT-1.
module seq_cycle_ctr #(
   parameter int CW      = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          term
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign term = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/run_sequencer.sv
// Host-side sequencer: loads a message into dat_mem, runs the core until done
// or timeout, then streams the result block back out of dat_mem.
module run_sequencer
   import seq_pkg::*;
#(
   parameter int LOAD_BASE = 0,
   parameter int LOAD_LEN  = 30,
   parameter int DUMP_BASE = 30,
   parameter int DUMP_LEN  = 30,
   parameter int TIMEOUT   = 4096,
   parameter int CW        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   output logic              core_reset,
   output logic              core_req,
   input  logic              core_done,
   output logic              mem_sel,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wr_dat,
   input  logic [7:0]        mem_rd_dat,
   output logic              busy,
   output logic              finished,
   output logic              timeout,
   output logic [CW-1:0]     cycles
);

   if (LOAD_LEN < 1 || LOAD_LEN > 256) begin : g_bad_load_len
      $error("run_sequencer: LOAD_LEN must be in 1..256");
   end
   if (DUMP_LEN < 1 || DUMP_LEN > 256) begin : g_bad_dump_len
      $error("run_sequencer: DUMP_LEN must be in 1..256");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("run_sequencer: TIMEOUT must be at least 2");
   end
   if (CW < 1 || CW > 62 || (64'd1 << CW) <= 64'(TIMEOUT)) begin : g_bad_cw
      $error("run_sequencer: 2**CW must exceed TIMEOUT");
   end

   localparam logic [8:0]        LOAD_LAST   = 9'(LOAD_LEN - 1);
   localparam logic [8:0]        DUMP_LAST   = 9'(DUMP_LEN - 1);
   localparam logic [ADDR_W-1:0] LOAD_BASE_A = ADDR_W'(LOAD_BASE);
   localparam logic [ADDR_W-1:0] DUMP_BASE_A = ADDR_W'(DUMP_BASE);

   seq_state_t        state, state_nxt;
   logic [8:0]        idx;
   logic              launch;
   logic              done_ok;
   logic              term;
   logic [ADDR_W-1:0] load_addr, dump_addr;

   assign launch    = start && (state == IDLE || state == FINISH);
   // The counter is cleared at launch, so a zero count marks the first RUN cycle.
   assign done_ok   = core_done && (cycles != '0);
   assign load_addr = LOAD_BASE_A + idx[ADDR_W-1:0];
   assign dump_addr = DUMP_BASE_A + idx[ADDR_W-1:0];

   seq_cycle_ctr #(
      .CW      (CW),
      .TIMEOUT (TIMEOUT)
   ) u_cycle_ctr (
      .clk   (clk),
      .reset (reset),
      .clr   (launch),
      .en    ((state == RUN) && !term),
      .count (cycles),
      .term  (term)
   );

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: the default assignment first means every path drives state_nxt,
      // so no latch can be inferred.
      state_nxt = state;
      case (state)
         IDLE, FINISH: if (start) state_nxt = LOAD;
         LOAD:         if (in_valid && idx == LOAD_LAST) state_nxt = RUN;
         RUN: begin
            if (done_ok) begin
               state_nxt = DUMP;
            end else if (term) begin
               state_nxt = FINISH;
            end
         end
         DUMP:         if (out_ready && idx == DUMP_LAST) state_nxt = FINISH;
         default:      state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx     <= '0;
         timeout <= 1'b0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               if (start) begin
                  idx     <= '0;
                  timeout <= 1'b0;
               end
            end
            LOAD: begin
               if (in_valid) idx <= (idx == LOAD_LAST) ? 9'd0 : idx + 9'd1;
            end
            RUN: begin
               if (!done_ok && term) timeout <= 1'b1;
            end
            DUMP: begin
               if (out_ready) idx <= (idx == DUMP_LAST) ? 9'd0 : idx + 9'd1;
            end
            default: idx <= '0;
         endcase
      end
   end

   assign mem_wr_dat = in_data;
   assign out_data   = mem_rd_dat;

   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      core_reset = 1'b1;
      core_req   = 1'b0;
      mem_sel    = 1'b1;
      mem_wr_en  = 1'b0;
      mem_addr   = load_addr;
      busy       = 1'b0;
      finished   = 1'b0;
      case (state)
         LOAD: begin
            in_ready  = 1'b1;
            mem_wr_en = in_valid;
            busy      = 1'b1;
         end
         RUN: begin
            core_reset = 1'b0;
            core_req   = 1'b1;
            mem_sel    = 1'b0;
            busy       = 1'b1;
         end
         DUMP: begin
            out_valid = 1'b1;
            mem_addr  = dump_addr;
            busy      = 1'b1;
         end
         FINISH:  finished = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer with a stub core and a dat_mem model.
module tb_run_sequencer;

   localparam int LOAD_LEN    = 4;
   localparam int DUMP_LEN    = 4;
   localparam int LOAD_BASE   = 0;
   localparam int LOAD_BASE_W = 254;
   localparam int DUMP_BASE   = 8;
   localparam int TIMEOUT     = 20;
   localparam int CW          = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          out_ready = 1'b1;
   logic          core_done;

   logic          in_ready, out_valid, core_reset, core_req, mem_sel, mem_wr_en;
   logic [7:0]    out_data, mem_addr, mem_wr_dat, mem_rd_dat;
   logic          busy, finished, timeout;
   logic [CW-1:0] cycles;

   logic          in_ready_w, out_valid_w, core_reset_w, core_req_w, mem_sel_w, mem_wr_en_w;
   logic [7:0]    out_data_w, mem_addr_w, mem_wr_dat_w, mem_rd_dat_w;
   logic          busy_w, finished_w, timeout_w;
   logic [CW-1:0] cycles_w;

   always #5 clk = ~clk;

   run_sequencer #(
      .LOAD_BASE (LOAD_BASE), .LOAD_LEN (LOAD_LEN), .DUMP_BASE (DUMP_BASE),
      .DUMP_LEN (DUMP_LEN), .TIMEOUT (TIMEOUT), .CW (CW)
   ) dut (
      .clk (clk), .reset (reset), .start (start), .in_valid (in_valid),
      .in_data (in_data), .in_ready (in_ready), .out_valid (out_valid),
      .out_data (out_data), .out_ready (out_ready), .core_reset (core_reset),
      .core_req (core_req), .core_done (core_done), .mem_sel (mem_sel),
      .mem_wr_en (mem_wr_en), .mem_addr (mem_addr), .mem_wr_dat (mem_wr_dat),
      .mem_rd_dat (mem_rd_dat), .busy (busy), .finished (finished),
      .timeout (timeout), .cycles (cycles)
   );

   // Second instance, run in lockstep, exercises address wrap at the top of memory.
   run_sequencer #(
      .LOAD_BASE (LOAD_BASE_W), .LOAD_LEN (LOAD_LEN), .DUMP_BASE (DUMP_BASE),
      .DUMP_LEN (DUMP_LEN), .TIMEOUT (TIMEOUT), .CW (CW)
   ) dut_w (
      .clk (clk), .reset (reset), .start (start), .in_valid (in_valid),
      .in_data (in_data), .in_ready (in_ready_w), .out_valid (out_valid_w),
      .out_data (out_data_w), .out_ready (out_ready), .core_reset (core_reset_w),
      .core_req (core_req_w), .core_done (core_done), .mem_sel (mem_sel_w),
      .mem_wr_en (mem_wr_en_w), .mem_addr (mem_addr_w), .mem_wr_dat (mem_wr_dat_w),
      .mem_rd_dat (mem_rd_dat_w), .busy (busy_w), .finished (finished_w),
      .timeout (timeout_w), .cycles (cycles_w)
   );

   // Environment: dat_mem models, write logs, core_req counter, stub core.
   logic [7:0] mem   [256];
   logic [7:0] mem_w [256];
   logic       pre_we = 1'b0;
   logic [7:0] pre_addr = 8'h00, pre_dat = 8'h00;
   logic [7:0] wr_addr [1024];
   logic [7:0] wr_dat  [1024];
   logic [7:0] wb_addr [1024];
   int         wr_n = 0, wb_n = 0, req_n = 0, run_i = 0;
   int         done_after = 0;

   assign mem_rd_dat   = mem[mem_addr];
   assign mem_rd_dat_w = mem_w[mem_addr_w];
   assign core_done    = (done_after != 0) && (run_i == done_after);

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_addr] <= pre_dat;
      end else if (reset && mem_sel && mem_wr_en) begin
         mem[mem_addr]       <= mem_wr_dat;
         wr_addr[wr_n[9:0]]  <= mem_addr;
         wr_dat[wr_n[9:0]]   <= mem_wr_dat;
         wr_n                <= wr_n + 1;
      end
      if (reset && mem_sel_w && mem_wr_en_w) begin
         mem_w[mem_addr_w]   <= mem_wr_dat_w;
         wb_addr[wb_n[9:0]]  <= mem_addr_w;
         wb_n                <= wb_n + 1;
      end
      if (core_req) req_n <= req_n + 1;
   end

   always @(negedge clk) begin
      if (!core_reset) run_i <= run_i + 1;
      else             run_i <= 0;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Bench-side reference state and per-run observations.
   int         n_checks = 0, n_fail = 0;
   logic [7:0] ref_mem [256];
   logic [7:0] ld_bytes [LOAD_LEN];
   logic [7:0] dump_q [$];
   int         load_cyc, dump_cyc, run_req, stall_seen, wr_base, wb_base;
   bit         stall_bad, rel_ok, first_ready, fin_o, to_o;
   logic [CW-1:0] cyc_o;
   logic [7:0] hold_d, hold_a;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      pre_addr = a; pre_dat = v; pre_we = 1'b1;
      tick;
      pre_we = 1'b0;
      ref_mem[a] = v;
   endtask

   task automatic randomize_load;
      for (int k = 0; k < LOAD_LEN; k++) ld_bytes[k] = 8'($urandom);
   endtask

   // Drives one full start/load/run/dump sequence and records what was seen.
   task automatic do_run(input int d, input bit toggle, input int stall_at,
                         input int stall_len, input bit start_mid);
      int  k, beat, guard, cnt, stalled, req0;
      bit  acc;
      done_after = d;
      dump_q.delete();
      stall_bad = 0; stall_seen = 0; hold_d = 8'h00; hold_a = 8'h00;
      wr_base = wr_n; wb_base = wb_n; req0 = req_n;
      start = 1'b1;
      tick;
      start = 1'b0;
      first_ready = in_ready && busy;
      k = 0; beat = 0; guard = 0;
      while (k < LOAD_LEN && guard < 300) begin
         in_valid = toggle ? ~beat[0] : 1'b1;
         in_data  = in_valid ? ld_bytes[k] : 8'($urandom);
         start    = start_mid && (beat == 1);
         acc      = in_valid && in_ready;
         tick;
         if (acc) k++;
         beat++; guard++;
      end
      in_valid = 1'b0; start = 1'b0;
      load_cyc = beat;
      rel_ok = (core_reset === 1'b0) && (core_req === 1'b1) && (mem_sel === 1'b0);
      while (core_req && guard < 300) begin
         tick;
         guard++;
      end
      cnt = 0; stalled = 0; dump_cyc = 0;
      while (out_valid && guard < 300) begin
         if (cnt == stall_at && stalled < stall_len) begin
            out_ready = 1'b0;
            if (stalled == 0) begin
               hold_d = out_data; hold_a = mem_addr;
            end else if (out_data !== hold_d || mem_addr !== hold_a) begin
               stall_bad = 1;
            end
            stalled++; stall_seen++;
         end else begin
            out_ready = 1'b1;
            if (stalled != 0 && cnt == stall_at && out_data !== hold_d) stall_bad = 1;
            dump_q.push_back(out_data);
            cnt++;
         end
         tick;
         guard++; dump_cyc++;
      end
      out_ready = 1'b1;
      n_checks++;
      if (guard >= 300) begin
         n_fail++;
         $display("FAIL run_bound: sequence did not complete within %0d cycles", guard);
      end
      run_req = req_n - req0;
      fin_o = finished; to_o = timeout; cyc_o = cycles;
      for (int j = 0; j < LOAD_LEN; j++) ref_mem[(LOAD_BASE + j) % 256] = ld_bytes[j];
   endtask

   task automatic test_reset;
      #1 reset = 1'b0;
      #1;
      n_checks++;
      if ({core_reset, mem_sel, core_req, in_ready, out_valid, mem_wr_en, busy, finished, timeout}
          !== 9'b110000000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected %b",
                  {core_reset, mem_sel, core_req, in_ready, out_valid, mem_wr_en, busy,
                   finished, timeout}, 9'b110000000);
      end
      n_checks++;
      if (cycles !== '0) begin
         n_fail++; $display("FAIL reset_cycles: got %0d expected 0", cycles);
      end
      n_checks++;
      if (mem_addr !== 8'(LOAD_BASE) || mem_addr_w !== 8'(LOAD_BASE_W)) begin
         n_fail++;
         $display("FAIL reset_addr: got %0d/%0d expected %0d/%0d", mem_addr, mem_addr_w,
                  LOAD_BASE, LOAD_BASE_W);
      end
      #3 reset = 1'b1;
      tick;
   endtask

   task automatic test_normal;
      for (int j = 0; j < DUMP_LEN; j++) preload(8'(DUMP_BASE + j), 8'hA0 + 8'(j));
      ld_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_run(6, 0, -1, 0, 0);
      n_checks++;
      if (!first_ready) begin n_fail++; $display("FAIL normal_in_ready: got 0 expected 1"); end
      n_checks++;
      if (wr_n - wr_base != LOAD_LEN) begin
         n_fail++; $display("FAIL normal_wr_count: got %0d expected %0d", wr_n - wr_base, LOAD_LEN);
      end
      for (int j = 0; j < LOAD_LEN; j++) begin
         n_checks++;
         if (wr_addr[wr_base + j] !== 8'(LOAD_BASE + j) || wr_dat[wr_base + j] !== ld_bytes[j]) begin
            n_fail++;
            $display("FAIL normal_write%0d: got %0d:%h expected %0d:%h", j, wr_addr[wr_base + j],
                     wr_dat[wr_base + j], LOAD_BASE + j, ld_bytes[j]);
         end
      end
      n_checks++;
      if (!rel_ok) begin n_fail++; $display("FAIL normal_release: got 0 expected 1"); end
      n_checks++;
      if (run_req != 6 || cyc_o !== 16'd6) begin
         n_fail++; $display("FAIL normal_run_len: got req=%0d cycles=%0d expected 6/6", run_req, cyc_o);
      end
      n_checks++;
      if (dump_q.size() != DUMP_LEN || dump_cyc != DUMP_LEN) begin
         n_fail++;
         $display("FAIL normal_dump_len: got %0d bytes in %0d cycles expected %0d/%0d",
                  dump_q.size(), dump_cyc, DUMP_LEN, DUMP_LEN);
      end
      for (int j = 0; j < dump_q.size() && j < DUMP_LEN; j++) begin
         n_checks++;
         if (dump_q[j] !== ref_mem[(DUMP_BASE + j) % 256]) begin
            n_fail++;
            $display("FAIL normal_dump%0d: got %h expected %h", j, dump_q[j],
                     ref_mem[(DUMP_BASE + j) % 256]);
         end
      end
      n_checks++;
      if (fin_o !== 1'b1 || to_o !== 1'b0) begin
         n_fail++; $display("FAIL normal_flags: got fin=%b to=%b expected 1/0", fin_o, to_o);
      end
   endtask

   task automatic test_backpressure;
      randomize_load();
      do_run(6, 1, 1, 3, 0);
      n_checks++;
      if (wr_n - wr_base != LOAD_LEN || load_cyc != 2 * LOAD_LEN - 1) begin
         n_fail++;
         $display("FAIL bp_load: got %0d writes in %0d cycles expected %0d/%0d",
                  wr_n - wr_base, load_cyc, LOAD_LEN, 2 * LOAD_LEN - 1);
      end
      for (int j = 0; j < LOAD_LEN; j++) begin
         n_checks++;
         if (wr_addr[wr_base + j] !== 8'(LOAD_BASE + j) || wr_dat[wr_base + j] !== ld_bytes[j]) begin
            n_fail++;
            $display("FAIL bp_write%0d: got %0d:%h expected %0d:%h", j, wr_addr[wr_base + j],
                     wr_dat[wr_base + j], LOAD_BASE + j, ld_bytes[j]);
         end
      end
      n_checks++;
      if (stall_seen != 3 || stall_bad || hold_d !== ref_mem[DUMP_BASE + 1] ||
          hold_a !== 8'(DUMP_BASE + 1)) begin
         n_fail++;
         $display("FAIL bp_stall: got %0d cycles data=%h addr=%0d unstable=%0d expected 3/%h/%0d/0",
                  stall_seen, hold_d, hold_a, stall_bad, ref_mem[DUMP_BASE + 1], DUMP_BASE + 1);
      end
      n_checks++;
      if (dump_q.size() != DUMP_LEN || dump_cyc != DUMP_LEN + 3) begin
         n_fail++;
         $display("FAIL bp_dump_len: got %0d bytes in %0d cycles expected %0d/%0d",
                  dump_q.size(), dump_cyc, DUMP_LEN, DUMP_LEN + 3);
      end
      for (int j = 0; j < dump_q.size() && j < DUMP_LEN; j++) begin
         n_checks++;
         if (dump_q[j] !== ref_mem[(DUMP_BASE + j) % 256]) begin
            n_fail++;
            $display("FAIL bp_dump%0d: got %h expected %h", j, dump_q[j],
                     ref_mem[(DUMP_BASE + j) % 256]);
         end
      end
   endtask

   task automatic test_timeout;
      randomize_load();
      do_run(0, 0, -1, 0, 0);
      n_checks++;
      if (run_req != TIMEOUT || cyc_o !== 16'(TIMEOUT - 1)) begin
         n_fail++;
         $display("FAIL timeout_len: got req=%0d cycles=%0d expected %0d/%0d", run_req, cyc_o,
                  TIMEOUT, TIMEOUT - 1);
      end
      n_checks++;
      if (to_o !== 1'b1 || fin_o !== 1'b1 || dump_q.size() != 0) begin
         n_fail++;
         $display("FAIL timeout_flags: got to=%b fin=%b dumped=%0d expected 1/1/0", to_o, fin_o,
                  dump_q.size());
      end
   endtask

   task automatic test_collision;
      randomize_load();
      do_run(TIMEOUT, 0, -1, 0, 0);
      n_checks++;
      if (to_o !== 1'b0 || dump_q.size() != DUMP_LEN || run_req != TIMEOUT) begin
         n_fail++;
         $display("FAIL collision: got to=%b dumped=%0d req=%0d expected 0/%0d/%0d", to_o,
                  dump_q.size(), run_req, DUMP_LEN, TIMEOUT);
      end
   endtask

   task automatic test_wrap_ignore;
      randomize_load();
      do_run(6, 0, -1, 0, 1);
      n_checks++;
      if (wb_n - wb_base != LOAD_LEN || wr_n - wr_base != LOAD_LEN || load_cyc != LOAD_LEN) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d/%0d writes in %0d cycles expected %0d", wb_n - wb_base,
                  wr_n - wr_base, load_cyc, LOAD_LEN);
      end
      for (int j = 0; j < LOAD_LEN; j++) begin
         n_checks++;
         if (wb_addr[wb_base + j] !== 8'((LOAD_BASE_W + j) % 256)) begin
            n_fail++;
            $display("FAIL wrap_addr%0d: got %0d expected %0d", j, wb_addr[wb_base + j],
                     (LOAD_BASE_W + j) % 256);
         end
      end
      n_checks++;
      if (fin_o !== 1'b1 || cyc_o !== 16'd6 || dump_q.size() != DUMP_LEN) begin
         n_fail++;
         $display("FAIL ignore_start: got fin=%b cycles=%0d dumped=%0d expected 1/6/%0d", fin_o,
                  cyc_o, dump_q.size(), DUMP_LEN);
      end
   endtask

   task automatic test_async_reset;
      int w0;
      done_after = 0;
      start = 1'b1;
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < LOAD_LEN; k++) begin
         in_data = 8'($urandom);
         tick;
      end
      in_valid = 1'b0;
      repeat (3) tick;
      n_checks++;
      if (core_req !== 1'b1) begin n_fail++; $display("FAIL arst_in_run: got 0 expected 1"); end
      w0 = wr_n;
      #3 reset = 1'b0;
      #1;
      n_checks++;
      if ({core_reset, core_req, mem_sel, busy} !== 4'b1010 || cycles !== '0) begin
         n_fail++;
         $display("FAIL arst_state: got %b cycles=%0d expected 1010/0",
                  {core_reset, core_req, mem_sel, busy}, cycles);
      end
      #2 reset = 1'b1;
      tick;
      n_checks++;
      if (wr_n != w0) begin
         n_fail++; $display("FAIL arst_no_write: got %0d writes expected 0", wr_n - w0);
      end
      randomize_load();
      do_run(6, 0, -1, 0, 0);
      n_checks++;
      if (wr_n - wr_base != LOAD_LEN || wr_addr[wr_base] !== 8'(LOAD_BASE) ||
          wr_dat[wr_base] !== ld_bytes[0] || fin_o !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_restart: got %0d writes first %0d:%h fin=%b expected %0d %0d:%h 1",
                  wr_n - wr_base, wr_addr[wr_base], wr_dat[wr_base], fin_o, LOAD_LEN, LOAD_BASE,
                  ld_bytes[0]);
      end
   endtask

   // Back-to-back random runs against the rule-level model of one run.
   task automatic test_back_to_back;
      for (int it = 0; it < 10; it++) begin
         int  d, s_at, s_len, exp_req;
         bit  tog, dumps;
         for (int j = 0; j < DUMP_LEN; j++) preload(8'(DUMP_BASE + j), 8'($urandom));
         randomize_load();
         d     = $urandom_range(1, TIMEOUT + 4);
         tog   = 1'($urandom);
         s_at  = $urandom_range(0, DUMP_LEN - 1);
         s_len = $urandom_range(0, 3);
         do_run(d, tog, s_at, s_len, 0);
         dumps   = (d >= 2) && (d <= TIMEOUT);
         exp_req = dumps ? d : TIMEOUT;
         n_checks++;
         if (run_req != exp_req || cyc_o !== 16'((exp_req < TIMEOUT) ? exp_req : TIMEOUT - 1) ||
             to_o !== !dumps || fin_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b%0d_run: got req=%0d cycles=%0d to=%b fin=%b for done_after=%0d",
                     it, run_req, cyc_o, to_o, fin_o, d);
         end
         n_checks++;
         if (wr_n - wr_base != LOAD_LEN || wr_dat[wr_base + LOAD_LEN - 1] !== ld_bytes[LOAD_LEN - 1]) begin
            n_fail++;
            $display("FAIL b2b%0d_load: got %0d writes last %h expected %0d last %h", it,
                     wr_n - wr_base, wr_dat[wr_base + LOAD_LEN - 1], LOAD_LEN, ld_bytes[LOAD_LEN - 1]);
         end
         n_checks++;
         if (dump_q.size() != (dumps ? DUMP_LEN : 0) ||
             (dumps && dump_cyc != DUMP_LEN + s_len) || stall_bad) begin
            n_fail++;
            $display("FAIL b2b%0d_dump_len: got %0d bytes in %0d cycles unstable=%0d", it,
                     dump_q.size(), dump_cyc, stall_bad);
         end
         for (int j = 0; j < dump_q.size() && j < DUMP_LEN; j++) begin
            n_checks++;
            if (dump_q[j] !== ref_mem[(DUMP_BASE + j) % 256]) begin
               n_fail++;
               $display("FAIL b2b%0d_dump%0d: got %h expected %h", it, j, dump_q[j],
                        ref_mem[(DUMP_BASE + j) % 256]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_backpressure();
      test_timeout();
      test_collision();
      test_wrap_ignore();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
